logic_unit_pipe: RTL and testbench
==================================

Name: logic_unit_pipe

Overview:
- Parametrised, registered successor to the team's 8-bit combinational logic-ops block.
- Per accepted transaction, computes one selected bitwise operation on WIDTH-bit operands.
- Result is registered, together with zero, parity and popcount flags.
- Optional chain mode uses the previous result as operand A, so the block can fold a stream of words (running AND/OR/XOR masks).
- Sits between a valid/ready producer and consumer in datapath glue logic.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 1..64.
- CW, $clog2(WIDTH+1), width of the popcount output; derived, not overridden.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  producer has a transaction.
- in_ready  out  1  block can accept this cycle.
- a  in  WIDTH  operand A (ignored when chain=1).
- b  in  WIDTH  operand B.
- op  in  3  operation select: 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR, 6 PASS_X, 7 NOT_X.
- chain  in  1  use accumulator as operand X instead of a.
- acc_clr  in  1  synchronous clear of the accumulator.
- out_valid  out  1  result registers hold an unconsumed result.
- out_ready  in  1  consumer takes the result.
- result  out  WIDTH  registered operation result.
- zero  out  1  result == 0.
- parity  out  1  XOR-reduction of result.
- ones  out  CW  number of 1 bits in result.

Behaviour:
- Reset (rst=1, asynchronous, effective immediately, also mid-transaction):
  - out_valid=0, result=0, zero=0, parity=0, ones=0, internal acc=0.
  - Any held result is discarded.
- in_ready = !out_valid | out_ready (combinational). in_ready is 1 while in reset and on the first cycle after reset.
- accept = in_valid & in_ready. Latency 1 cycle; throughput 1 transaction per cycle under continuous out_ready.
- Operand selection: X = chain ? acc_eff : a; Y = b.
  - acc_eff = acc_clr ? 0 : acc.
- Operations: bitwise over WIDTH bits. PASS_X = X, NOT_X = ~X; both ignore b.
- On accept, at the clock edge:
  - result <= f(op,X,Y); out_valid <= 1.
  - zero, parity and ones are registered from the same new value, never computed from the output.
  - acc <= new result (every accepted op updates acc, chained or not).
- acc_clr without accept: acc <= 0; outputs unchanged.
- acc_clr with accept: the cleared value feeds X if chain=1, and acc then takes the new result.
- No accept and out_ready=1: out_valid <= 0; result and flags keep their last values.
- Stall (out_valid=1, out_ready=0):
  - in_ready=0.
  - result, flags and acc are held stable.
  - a, b, op, chain are don't-care.
  - acc_clr still clears acc.
- Simultaneous out_ready and in_valid while out_valid=1: old result consumed and new result loaded on the same edge, with no bubble.
- Popcount: unsigned, 0..WIDTH, no overflow by construction of CW. WIDTH=1 gives CW=1.
- No X propagation from op: all 8 encodings are defined.

Decomposition:
- Shared package logic_ops_pkg:
  - opcode localparams OP_AND..OP_NOT_X (3 bits);
  - a popcount function.
- One sub-module, logic_ops_core: purely combinational. Takes (op, x, y), returns WIDTH-bit result. Reusable by the other logic blocks.
- Handshake, accumulator and flag registers stay in logic_unit_pipe.

Test Plan (WIDTH=8):
1. Reset mid-stall: load a=8'hF0,b=8'h3C,op=AND, hold out_ready=0, assert rst. Expected: out_valid=0, result=0 immediately, in_ready=1; after release, acc=0.
2. All ops, a=8'hCA,b=8'h5F, out_ready=1, back-to-back. Expected results one cycle later: 4A, B5, DF, 20, 95, 6A, CA, 35. Expected flags for 8'h4A: zero=0, parity=1, ones=3.
3. Chain fold: acc_clr=1 with first accept, chain=1, op=OR, b=01,02,04,80. Expected results 01,03,07,87; final ones=4.
4. Backpressure: stream 4 XOR transactions, out_ready low 3 cycles mid-stream. Expected: in_ready=0 during the stall, result stable, no loss or duplication, order preserved, full rate after release.
5. Zero flag: op=XOR, a=b=8'hA5. Expected: result=00, zero=1, parity=0, ones=0. Then op=NAND, a=b=8'h00: result=FF, ones=8.
6. acc_clr while stalled: chain fold to acc=8'h0F, stall, pulse acc_clr, release, accept chain=1 op=OR b=8'h10. Expected: result=8'h10.

Source files
------------

// File: rtl/logic_ops_pkg.sv
// logic_ops_pkg: opcode encodings and popcount helper shared by the logic-op blocks
package logic_ops_pkg;
    localparam logic [2:0] OP_AND    = 3'd0;
    localparam logic [2:0] OP_NAND   = 3'd1;
    localparam logic [2:0] OP_OR     = 3'd2;
    localparam logic [2:0] OP_NOR    = 3'd3;
    localparam logic [2:0] OP_XOR    = 3'd4;
    localparam logic [2:0] OP_XNOR   = 3'd5;
    localparam logic [2:0] OP_PASS_X = 3'd6;
    localparam logic [2:0] OP_NOT_X  = 3'd7;

    function automatic logic [6:0] popcount(input logic [63:0] v);
        logic [6:0] c;
        c = '0;
        for (int i = 0; i < 64; i++) c = c + {6'd0, v[i]};
        return c;
    endfunction
endpackage

// File: rtl/logic_ops_core.sv
// logic_ops_core: combinational bitwise op select; odd opcodes are the inverted form of the even one below
module logic_ops_core #(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] r
);
    logic [WIDTH-1:0] t;
    always_comb begin
        t = op[2:1] == 2'd0 ? (x & y) :
            op[2:1] == 2'd1 ? (x | y) :
            op[2:1] == 2'd2 ? (x ^ y) : x;
        r = op[0] ? ~t : t;
    end
endmodule

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: registered logic-op stage with valid/ready handshake, result flags and chain accumulator
module logic_unit_pipe
    import logic_ops_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int CW = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             chain,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             parity,
    output logic [CW-1:0]    ones
);
    logic [WIDTH-1:0] acc, acc_eff, x, f;
    logic accept;

    assign in_ready = !out_valid | out_ready;
    assign accept   = in_valid & in_ready;
    assign acc_eff  = acc_clr ? '0 : acc;
    assign x        = chain ? acc_eff : a;

    logic_ops_core #(.WIDTH(WIDTH)) u_core (.op(op), .x(x), .y(b), .r(f));

    // Flags come from the new value so they stay aligned with result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            parity    <= 1'b0;
            ones      <= '0;
            acc       <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            result    <= f;
            zero      <= f == '0;
            parity    <= ^f;
            ones      <= CW'(popcount(64'(f)));
            acc       <= f;
        end else begin
            if (acc_clr) acc <= '0;
            if (out_ready) out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb_logic_unit_pipe: directed vectors with hand-computed results for logic_unit_pipe at WIDTH=8
module tb_logic_unit_pipe;
    import logic_ops_pkg::*;

    logic       clk = 1'b0, rst = 1'b1;
    logic       in_valid = 1'b0, in_ready, chain = 1'b0, acc_clr = 1'b0;
    logic       out_valid, out_ready = 1'b0, zero, parity;
    logic [7:0] a = '0, b = '0, result;
    logic [2:0] op = OP_AND;
    logic [3:0] ones;
    int checks = 0, errors = 0;

    logic_unit_pipe #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .chain(chain), .acc_clr(acc_clr),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .zero(zero), .parity(parity), .ones(ones)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] all_exp [8] = '{8'h4A, 8'hB5, 8'hDF, 8'h20, 8'h95, 8'h6A, 8'hCA, 8'h35};
    logic [7:0] fold_b  [4] = '{8'h01, 8'h02, 8'h04, 8'h80};
    logic [7:0] fold_e  [4] = '{8'h01, 8'h03, 8'h07, 8'h87};

    initial begin
        step();
        step();
        chk("rst_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_flags", {zero, parity, ones}, 0);
        rst = 1'b0;
        chk("post_rst_ready", in_ready, 1);

        // 1: reset while a result is stalled
        in_valid = 1; a = 8'hF0; b = 8'h3C; op = OP_AND; out_ready = 0;
        step();
        chk("t1_load", result, 8'h30);
        in_valid = 0;
        step();
        chk("t1_stall_ready", in_ready, 0);
        #2 rst = 1;
        #1;
        chk("t1_async_valid", out_valid, 0);
        chk("t1_async_result", result, 0);
        chk("t1_async_ready", in_ready, 1);
        step();
        rst = 0;
        in_valid = 1; chain = 1; op = OP_PASS_X; out_ready = 1;
        step();
        chk("t1_acc_zero", result, 0);
        chk("t1_acc_zflag", zero, 1);

        // 2: every opcode back-to-back
        chain = 0; a = 8'hCA; b = 8'h5F;
        for (int i = 0; i < 8; i++) begin
            op = 3'(i);
            step();
            chk($sformatf("t2_op%0d", i), result, all_exp[i]);
            chk($sformatf("t2_valid%0d", i), out_valid, 1);
            if (i == 0) chk("t2_flags4a", {zero, parity, ones}, {1'b0, 1'b1, 4'd3});
        end

        // 3: running OR fold starting from a cleared accumulator
        chain = 1; op = OP_OR;
        for (int i = 0; i < 4; i++) begin
            acc_clr = i == 0;
            b = fold_b[i];
            step();
            chk($sformatf("t3_fold%0d", i), result, fold_e[i]);
        end
        acc_clr = 0;
        chk("t3_ones", ones, 4);

        // 4: backpressure mid-stream
        chain = 0; op = OP_XOR; a = 8'hFF; b = 8'h01;
        step();
        chk("t4_r1", result, 8'hFE);
        b = 8'h02;
        step();
        chk("t4_r2", result, 8'hFD);
        b = 8'h03; out_ready = 0;
        #1 chk("t4_ready_drop", in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("t4_hold%0d", i), {out_valid, in_ready, result}, {1'b1, 1'b0, 8'hFD});
        end
        out_ready = 1;
        step();
        chk("t4_r3", result, 8'hFC);
        b = 8'h04;
        step();
        chk("t4_r4", result, 8'hFB);
        in_valid = 0;
        step();
        chk("t4_drain", {out_valid, result}, {1'b0, 8'hFB});

        // 5: zero and all-ones results
        in_valid = 1; op = OP_XOR; a = 8'hA5; b = 8'hA5;
        step();
        chk("t5_zero", {result, zero, parity, ones}, {8'h00, 1'b1, 1'b0, 4'd0});
        op = OP_NAND; a = 8'h00; b = 8'h00;
        step();
        chk("t5_ones", {result, zero, parity, ones}, {8'hFF, 1'b0, 1'b0, 4'd8});

        // 6: accumulator clear during a stall
        chain = 1; op = OP_OR; b = 8'h0F; acc_clr = 1;
        step();
        chk("t6_fold", result, 8'h0F);
        acc_clr = 0; in_valid = 0; out_ready = 0;
        step();
        acc_clr = 1;
        step();
        acc_clr = 0;
        chk("t6_stall_hold", {out_valid, result}, {1'b1, 8'h0F});
        in_valid = 1; out_ready = 1; b = 8'h10;
        step();
        chk("t6_cleared", result, 8'h10);
        in_valid = 0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
